// File: rtl/torv_bpred.sv
// torv_bpred: standalone branch-prediction unit for the torv32 pipeline.
// gshare direction predictor, direct-mapped BTB and an optional
// return-address stack enabled by defining TORV_BP_RAS_EN.
// After reset the BHT is swept to weakly-not-taken, one entry per cycle.
module torv_bpred #(
  parameter int BHT_ADDR_BITS = 12,
  parameter int HIST_BITS     = 12,
  parameter int BTB_ADDR_BITS = 6,
  parameter int RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pr_en,
  input  logic [31:0]              pr_pc,
  output logic                     pr_taken,
  output logic [BHT_ADDR_BITS-1:0] pr_index,
  output logic                     pr_btb_hit,
  output logic [31:0]              pr_target,
  output logic                     busy,
  input  logic                     up_valid,
  input  logic [BHT_ADDR_BITS-1:0] up_index,
  input  logic [31:0]              up_pc,
  input  logic                     up_taken,
  input  logic [31:0]              up_target,
  input  logic                     ras_push,
  input  logic [31:0]              ras_push_addr,
  input  logic                     ras_pop,
  output logic [31:0]              ras_top,
  output logic                     ras_valid
);

  localparam int BHT_SIZE = 1 << BHT_ADDR_BITS;
  localparam int BTB_SIZE = 1 << BTB_ADDR_BITS;
  localparam int TAG_W    = 32 - BTB_ADDR_BITS - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state;
  logic [BHT_ADDR_BITS-1:0] sweep;
  logic [HIST_BITS-1:0]     ghr;
  logic [1:0]               bht [BHT_SIZE];
  logic                     btb_valid [BTB_SIZE];
  logic [TAG_W-1:0]         btb_tag [BTB_SIZE];
  logic [31:0]              btb_target [BTB_SIZE];

  logic [BHT_ADDR_BITS-1:0] hist_ext;
  logic [BHT_ADDR_BITS-1:0] lk_idx;
  logic [BTB_ADDR_BITS-1:0] lk_entry;
  logic [TAG_W-1:0]         lk_tag;
  logic                     lk_hit;
  logic [BTB_ADDR_BITS-1:0] up_entry;
  logic [TAG_W-1:0]         up_tag;
  logic [1:0]               up_ctr;
  logic [1:0]               up_ctr_next;

  // History is left-aligned into the index so short histories fold onto the top PC bits.
  assign hist_ext = BHT_ADDR_BITS'(ghr) << (BHT_ADDR_BITS - HIST_BITS);
  assign lk_idx   = pr_pc[BHT_ADDR_BITS+1:2] ^ hist_ext;
  assign lk_entry = pr_pc[BTB_ADDR_BITS+1:2];
  assign lk_tag   = pr_pc[31:BTB_ADDR_BITS+2];
  assign lk_hit   = btb_valid[lk_entry] && (btb_tag[lk_entry] == lk_tag);
  assign up_entry = up_pc[BTB_ADDR_BITS+1:2];
  assign up_tag   = up_pc[31:BTB_ADDR_BITS+2];
  assign up_ctr   = bht[up_index];

  // Saturating 2-bit counter step for the resolved branch.
  always_comb begin
    up_ctr_next = up_ctr;
    if (up_taken) begin
      if (up_ctr != 2'b11) up_ctr_next = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr_next = up_ctr - 2'd1;
    end
  end

  // BHT storage: the init sweep owns the write port until RUN, then execute updates do.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      bht[sweep] <= 2'b01;
    end else if (up_valid) begin
      bht[up_index] <= up_ctr_next;
    end
  end

  // Sequencer, history, BTB and registered lookup results; reads see pre-edge state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      sweep      <= '0;
      busy       <= 1'b1;
      ghr        <= '0;
      pr_taken   <= 1'b0;
      pr_index   <= '0;
      pr_btb_hit <= 1'b0;
      pr_target  <= '0;
      for (int i = 0; i < BTB_SIZE; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (state == ST_INIT) begin
      sweep <= sweep + 1'b1;
      if (&sweep) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end
      if (pr_en) begin
        pr_taken   <= 1'b0;
        pr_index   <= lk_idx;
        pr_btb_hit <= 1'b0;
        pr_target  <= btb_target[lk_entry];
      end
    end else begin
      if (pr_en) begin
        pr_taken   <= bht[lk_idx][1];
        pr_index   <= lk_idx;
        pr_btb_hit <= lk_hit;
        pr_target  <= btb_target[lk_entry];
      end
      if (up_valid) begin
        ghr <= (ghr >> 1) | (HIST_BITS'(up_taken) << (HIST_BITS - 1));
        if (up_taken) begin
          btb_valid[up_entry]  <= 1'b1;
          btb_tag[up_entry]    <= up_tag;
          btb_target[up_entry] <= up_target;
        end
      end
    end
  end

`ifdef TORV_BP_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_ptr;
  logic [PTR_W-1:0] ras_next_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             unused_bits;

  assign unused_bits  = ^{pr_pc[1:0], up_pc[1:0]};
  assign ras_top_ptr  = (ras_ptr == '0) ? LAST_PTR : ras_ptr - PTR_W'(1);
  assign ras_next_ptr = (ras_ptr == LAST_PTR) ? '0 : ras_ptr + PTR_W'(1);
  assign ras_top      = ras_mem[ras_top_ptr];
  assign ras_valid    = (ras_cnt != '0);

  // Circular return stack; a pop on an empty stack is dropped, so push+pop there acts as a push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_push && ras_pop && (ras_cnt != '0)) begin
      ras_mem[ras_top_ptr] <= ras_push_addr;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= ras_push_addr;
      ras_ptr          <= ras_next_ptr;
      if (ras_cnt != FULL_CNT) ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_pop && (ras_cnt != '0)) begin
      ras_ptr <= ras_top_ptr;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_bits;

  assign unused_bits = ^{pr_pc[1:0], up_pc[1:0], ras_push, ras_push_addr, ras_pop};
  assign ras_top     = '0;
  assign ras_valid   = 1'b0;
`endif

endmodule
